// File: rtl/hiscore_access_sequencer.sv
// hiscore_access_sequencer
// Runs burst transfers between the dataslot bridge and the core's hiscore RAM port.
// Each request halts the CPU, waits for the pause to settle, then moves req_len bytes
// at consecutive (wrapping) addresses before the CPU is released.
// Ports:
//   clk, reset_n                 core clock, async active-low reset
//   req_valid/ready/write/addr/len  request handshake and descriptor
//   wr_valid/wr_data/wr_ready    byte stream into RAM (wr_ready is combinational)
//   rd_valid/rd_data/rd_ready    byte stream out of RAM
//   busy, done                   request in flight / one-cycle completion pulse
//   processor_halt               CPU pause
//   hs_access_write, hs_write_enable, hs_address, hs_data_in, hs_data_out  RAM port
module hiscore_access_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned HALT_SETTLE = 16,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH:0]   req_len,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  processor_halt,
  output logic                  hs_access_write,
  output logic                  hs_write_enable,
  output logic [ADDR_WIDTH-1:0] hs_address,
  output logic [7:0]            hs_data_in,
  input  logic [7:0]            hs_data_out
);

  localparam int unsigned LEN_W   = ADDR_WIDTH + 1;
  localparam int unsigned CNT_MAX = (HALT_SETTLE > RD_LATENCY) ? HALT_SETTLE : RD_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Settle counter runs 0..HALT_SETTLE-1; RAM ownership is claimed one count early
  // so hs_access_write is already high in the last settle cycle.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(HALT_SETTLE - 1);
  localparam logic [CNT_W-1:0] SETTLE_PRE  = CNT_W'((HALT_SETTLE > 1) ? HALT_SETTLE - 2 : 0);
  localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WR_WAIT,
    S_WR_STROBE,
    S_RD_ISSUE,
    S_RD_HOLD,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                  state;
  logic                    is_write;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [LEN_W-1:0]        remaining;
  logic [CNT_W-1:0]        cnt;

  // Write bytes are taken the same cycle they are offered while waiting for one.
  assign wr_ready = (state == S_WR_WAIT) && wr_valid;

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      is_write        <= 1'b0;
      cur_addr        <= '0;
      remaining       <= '0;
      cnt             <= '0;
      req_ready       <= 1'b1;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      processor_halt  <= 1'b0;
      hs_access_write <= 1'b0;
      hs_write_enable <= 1'b0;
      hs_address      <= '0;
      hs_data_in      <= '0;
    end else begin
      done            <= 1'b0;
      hs_write_enable <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            is_write       <= req_write;
            cur_addr       <= req_addr;
            remaining      <= req_len;
            cnt            <= '0;
            busy           <= 1'b1;
            processor_halt <= 1'b1;
            req_ready      <= 1'b0;
            if (req_len == '0) begin
              state <= S_RELEASE;
            end else begin
              state           <= S_SETTLE;
              hs_access_write <= (HALT_SETTLE == 1);
            end
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (is_write) begin
              state <= S_WR_WAIT;
            end else begin
              state      <= S_RD_ISSUE;
              hs_address <= cur_addr;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == SETTLE_PRE) begin
              hs_access_write <= 1'b1;
            end
          end
        end

        S_WR_WAIT: begin
          if (wr_valid) begin
            hs_write_enable <= 1'b1;
            hs_data_in      <= wr_data;
            hs_address      <= cur_addr;
            cur_addr        <= cur_addr + ADDR_WIDTH'(1);
            remaining       <= remaining - LEN_W'(1);
            state           <= S_WR_STROBE;
          end
        end

        // Strobe cycle; remaining was already decremented at byte acceptance.
        S_WR_STROBE: begin
          if (remaining == '0) begin
            state           <= S_RELEASE;
            hs_access_write <= 1'b0;
          end else begin
            state <= S_WR_WAIT;
          end
        end

        // Address is held for RD_LATENCY cycles, then the RAM output is captured.
        S_RD_ISSUE: begin
          if (cnt == RD_LAST) begin
            cnt      <= '0;
            rd_data  <= hs_data_out;
            rd_valid <= 1'b1;
            state    <= S_RD_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RD_HOLD: begin
          if (rd_ready) begin
            rd_valid  <= 1'b0;
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state           <= S_RELEASE;
              hs_access_write <= 1'b0;
            end else begin
              state      <= S_RD_ISSUE;
              hs_address <= cur_addr + ADDR_WIDTH'(1);
            end
          end
        end

        S_RELEASE: begin
          processor_halt <= 1'b0;
          done           <= 1'b1;
          state          <= S_DONE;
        end

        S_DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hiscore_access_sequencer.sv
// tb_hiscore_access_sequencer
// Directed bench for hiscore_access_sequencer with a latency-2 RAM model and
// edge monitors for strobes, halt/access cycles, done pulses and handshakes.
module tb_hiscore_access_sequencer;

  localparam int unsigned AW = 12;
  localparam int unsigned HS = 16;
  localparam int unsigned RL = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW:0]   req_len = '0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_ready;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          processor_halt;
  logic          hs_access_write;
  logic          hs_write_enable;
  logic [AW-1:0] hs_address;
  logic [7:0]    hs_data_in;
  logic [7:0]    hs_data_out;

  always #5 clk = ~clk;

  hiscore_access_sequencer #(
    .ADDR_WIDTH (AW),
    .HALT_SETTLE(HS),
    .RD_LATENCY (RL)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_ready       (rd_ready),
    .busy           (busy),
    .done           (done),
    .processor_halt (processor_halt),
    .hs_access_write(hs_access_write),
    .hs_write_enable(hs_write_enable),
    .hs_address     (hs_address),
    .hs_data_in     (hs_data_in),
    .hs_data_out    (hs_data_out)
  );

  // RAM model: unwritten locations return a fixed address pattern; two-stage read pipe.
  logic [7:0] mem     [0:4095];
  bit         written [0:4095];
  logic [7:0] pipe0 = '0;
  logic [7:0] pipe1 = '0;

  function automatic logic [7:0] pat(input logic [11:0] a);
    logic [7:0] lo3;
    lo3 = 8'(a[7:0] * 3);
    return lo3 ^ {4'h0, a[11:8]};
  endfunction

  always @(posedge clk) begin
    if (hs_write_enable) begin
      mem[hs_address]     <= hs_data_in;
      written[hs_address] <= 1'b1;
    end
    pipe0 <= written[hs_address] ? mem[hs_address] : pat(hs_address);
    pipe1 <= pipe0;
  end
  assign hs_data_out = pipe1;

  // Edge monitors (sample pre-edge values).
  int         halt_n = 0;
  int         done_n = 0;
  int         acc_n = 0;
  int         accept_n = 0;
  int         rdhs_n = 0;
  int         st_n = 0;
  int         run = 0;
  int         max_run = 0;
  logic [7:0] last_rd = '0;
  logic [11:0] st_addr [0:63];
  logic [7:0]  st_data [0:63];

  always @(posedge clk) begin
    if (processor_halt)        halt_n   <= halt_n + 1;
    if (done)                  done_n   <= done_n + 1;
    if (hs_access_write)       acc_n    <= acc_n + 1;
    if (req_valid && req_ready) accept_n <= accept_n + 1;
    if (rd_valid && rd_ready) begin
      rdhs_n  <= rdhs_n + 1;
      last_rd <= rd_data;
    end
    if (hs_write_enable) begin
      st_addr[st_n[5:0]] <= hs_address;
      st_data[st_n[5:0]] <= hs_data_in;
      st_n <= st_n + 1;
      run  <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic wr, input logic [11:0] a, input logic [12:0] len,
                           input bit hold);
    bit ok;
    ok = 1'b0;
    req_write = wr;
    req_addr  = a;
    req_len   = len;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    check_eq("req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_data  = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (wr_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("wr_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int         h0, d0, s0, a0, c, acc0, r0;
  logic [7:0] first;
  logic [7:0] wdat [0:2];
  logic [7:0] exp_rd [0:3];

  initial begin
    wdat   = '{8'hA5, 8'h5A, 8'hFF};
    exp_rd = '{8'hF5, 8'hF2, 8'h00, 8'h03};

    // Asynchronous reset with no clock edge yet.
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_ctrl_zero", 32'({busy, done, processor_halt, hs_access_write,
                                   hs_write_enable, wr_ready, rd_valid}), 32'd0);
    check_eq("rst_data_zero", 32'({hs_address, hs_data_in, rd_data}), 32'd0);
    cyc(); cyc();
    #2 reset_n = 1'b1;
    cyc();

    // Write 0x010 len 3.
    h0 = halt_n; d0 = done_n; s0 = st_n; a0 = acc_n;
    issue_req(1'b1, 12'h010, 13'd3, 1'b0);
    check_eq("wr_busy_halt", 32'({busy, processor_halt, req_ready}), 32'b110);
    for (int i = 0; i < 3; i++) send_byte(wdat[i]);
    wr_valid = 1'b0;
    wait_done(200, c);
    check_eq("wr_halt_off_at_done", 32'(processor_halt), 32'd0);
    cyc();
    check_eq("wr_idle_after", 32'({busy, done, req_ready}), 32'b001);
    cyc(); cyc();
    check_eq("wr_halt_cycles", 32'((halt_n - h0) >= int'(HS + 6)), 32'd1);
    check_eq("wr_access_cycles", 32'(acc_n - a0), 32'd7);
    check_eq("wr_done_pulses", 32'(done_n - d0), 32'd1);
    check_eq("wr_strobe_count", 32'(st_n - s0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("wr_strobe_addr%0d", i), 32'(st_addr[s0 + i]), 32'(12'h010 + i));
      check_eq($sformatf("wr_strobe_data%0d", i), 32'(st_data[s0 + i]), 32'(wdat[i]));
    end
    check_eq("wr_strobe_width", 32'(max_run), 32'd1);
    check_eq("wr_addr_holds", 32'(hs_address), 32'h012);

    // Read 0xFFE len 4 with wrap and stalls.
    d0 = done_n; s0 = st_n;
    rd_ready = 1'b0;
    issue_req(1'b0, 12'hFFE, 13'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (rd_valid) ok = 1'b1;
      end
      check_eq("rd_valid_seen", 32'(ok), 32'd1);
      first = rd_data;
      check_eq($sformatf("rd_byte%0d", k), 32'(rd_data), 32'(exp_rd[k]));
      for (int s = 0; s < ((k % 2 == 0) ? 2 : 0); s++) begin
        @(negedge clk);
        check_eq("rd_stall_stable", 32'({rd_valid, rd_data}), 32'({1'b1, first}));
      end
      rd_ready = 1'b1;
      @(posedge clk);
      #1;
      rd_ready = 1'b0;
      @(negedge clk);
      check_eq("rd_valid_drop", 32'(rd_valid), 32'd0);
    end
    wait_done(100, c);
    cyc(); cyc();
    check_eq("rd_done_pulses", 32'(done_n - d0), 32'd1);
    check_eq("rd_no_strobe", 32'(st_n - s0), 32'd0);

    // Zero-length request.
    s0 = st_n; a0 = acc_n;
    issue_req(1'b1, 12'h050, 13'd0, 1'b0);
    wait_done(int'(HS + 4), c);
    check_eq("len0_latency", 32'(c <= int'(HS + 4)), 32'd1);
    cyc();
    check_eq("len0_no_strobe", 32'(st_n - s0), 32'd0);
    check_eq("len0_no_access", 32'(acc_n - a0), 32'd0);

    // Reset during the second byte of a len 8 write.
    s0 = st_n; d0 = done_n;
    issue_req(1'b1, 12'h100, 13'd8, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    check_eq("abort_strobe_live", 32'(hs_write_enable), 32'd1);
    #2 reset_n = 1'b0;
    wr_valid = 1'b0;
    #1;
    check_eq("abort_outputs", 32'({processor_halt, hs_write_enable, hs_access_write, busy, done}),
             32'd0);
    check_eq("abort_req_ready", 32'(req_ready), 32'd1);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc(); cyc(); cyc();
    check_eq("abort_strobes", 32'(st_n - s0), 32'd1);
    check_eq("abort_no_done", 32'(done_n - d0), 32'd0);
    s0 = st_n; d0 = done_n;
    issue_req(1'b1, 12'h200, 13'd2, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    wr_valid = 1'b0;
    wait_done(200, c);
    cyc(); cyc();
    check_eq("post_rst_done", 32'(done_n - d0), 32'd1);
    check_eq("post_rst_strobes", 32'(st_n - s0), 32'd2);
    check_eq("post_rst_s0", 32'({st_addr[s0], st_data[s0]}), 32'({12'h200, 8'h33}));
    check_eq("post_rst_s1", 32'({st_addr[s0 + 1], st_data[s0 + 1]}), 32'({12'h201, 8'h44}));

    // req_valid held high across reads: one execution per acceptance.
    acc0 = accept_n; d0 = done_n; r0 = rdhs_n;
    rd_ready = 1'b1;
    issue_req(1'b0, 12'h020, 13'd1, 1'b1);
    wait_done(200, c);
    wait_done(200, c);
    req_valid = 1'b0;
    rd_ready  = 1'b0;
    cyc(); cyc(); cyc();
    check_eq("hold_accepts", 32'(accept_n - acc0), 32'd2);
    check_eq("hold_dones", 32'(done_n - d0), 32'd2);
    check_eq("hold_rd_bytes", 32'(rdhs_n - r0), 32'd2);
    check_eq("hold_rd_data", 32'(last_rd), 32'h60);
    check_eq("hold_idle", 32'({busy, req_ready, processor_halt}), 32'b010);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
